// File: rtl/second_layer_bp_pkg.sv
// Shared types and helpers for the second-layer backprop driver.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package second_layer_bp_pkg;

  // Q4.12 fixed-point format
  localparam int Q_FRAC       = 12;
  localparam int Q_TARGET_ONE = 4096;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALC,
    S_BACK,
    S_UPDATE,
    S_DONE
  } state_e;

  // Clamp a wide signed value into the signed range of a w-bit word.
  // The caller truncates the result to w bits.
  function automatic logic signed [63:0] sat(input logic signed [63:0] x, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (x > hi) begin
      sat = hi;
    end else if (x < lo) begin
      sat = lo;
    end else begin
      sat = x;
    end
  endfunction

endpackage

// File: rtl/mul_shift_sat.sv
// Signed multiply, arithmetic right shift, optional negate, saturate to OW bits.
// Latency: 1 cycle (registered result, updated only on in_vld_i).
// Backpressure: none; accepts one operand pair per cycle, result holds otherwise.
module mul_shift_sat
  import second_layer_bp_pkg::*;
#(
  parameter int AW  = 16,
  parameter int BW  = 26,
  parameter int OW  = 16,
  parameter int SHW = 5
) (
  input  logic                 clk,
  input  logic                 reset_b,
  input  logic                 in_vld_i,
  input  logic signed [AW-1:0] a_i,
  input  logic signed [BW-1:0] b_i,
  input  logic [SHW-1:0]       shift_i,
  input  logic                 neg_i,
  output logic signed [OW-1:0] res_o
);

  localparam int PW = AW + BW;

  logic signed [PW-1:0] prod;
  logic signed [63:0]   shifted;
  logic signed [63:0]   scaled;
  logic signed [OW-1:0] res_d;
  logic signed [OW-1:0] res_q;

  // Full-precision product, shift before negate, saturate last so -(-2^15) cannot wrap.
  always_comb begin
    prod    = PW'(a_i) * PW'(b_i);
    shifted = 64'(prod) >>> shift_i;
    scaled  = neg_i ? -shifted : shifted;
    res_d   = in_vld_i ? OW'(sat(scaled, OW)) : res_q;
  end

  // Result register, holds between operand beats.
  always_ff @(posedge clk) begin
    if (!reset_b) begin
      res_q <= '0;
    end else begin
      res_q <= res_d;
    end
  end

  assign res_o = res_q;

endmodule

// File: rtl/second_layer_backprop.sv
// Training traffic for one second-layer cell: output error, back-propagated error, weight/bias deltas.
// Latency: back_error / delta_weight appear 1 cycle after their input beat; delta_bias set in CALC.
// Backpressure: none; beats may have gaps, FSM waits indefinitely, end_state2 ignored while busy.
module second_layer_backprop
  import second_layer_bp_pkg::*;
#(
  parameter int NWBITS     = 16,
  parameter int NHIDDEN    = 256,
  parameter int COUNT_BIT1 = 10,
  parameter int COUNT_BIT2 = 8,
  parameter int NUM        = 0,
  parameter int FRAC       = Q_FRAC,
  parameter int OUT_SHIFT  = 12,
  parameter int LR_SHIFT   = 7,
  parameter int TARGET_ONE = Q_TARGET_ONE
) (
  input  logic                                               clk,
  input  logic                                               reset_b,
  input  logic                                               end_state2,
  input  logic signed [2*NWBITS+COUNT_BIT2+COUNT_BIT1-1:0]   output_neuron,
  input  logic [3:0]                                         label,
  input  logic                                               weight_valid,
  input  logic signed [NWBITS-1:0]                           second_layer_weight,
  input  logic                                               hidden_valid,
  input  logic signed [NWBITS+COUNT_BIT1-1:0]                hidden_data,
  output logic                                               start_backprop,
  output logic signed [NWBITS-1:0]                           back_error,
  output logic                                               back_error_valid,
  output logic                                               update_second_layer,
  output logic signed [NWBITS-1:0]                           delta_weight,
  output logic signed [NWBITS-1:0]                           delta_bias,
  output logic                                               busy,
  output logic                                               done
);

  localparam int ONW = 2*NWBITS + COUNT_BIT2 + COUNT_BIT1;
  localparam int HW  = NWBITS + COUNT_BIT1;
  localparam int SHW = $clog2(FRAC + LR_SHIFT + 1);

  state_e                  state_q, state_d;
  logic [COUNT_BIT2-1:0]   cnt_q, cnt_d;
  logic signed [ONW-1:0]   on_q, on_d;
  logic [3:0]              label_q, label_d;
  logic signed [NWBITS-1:0] err_q, err_d;
  logic signed [NWBITS-1:0] dbias_q, dbias_d;
  logic                    be_vld_q, be_vld_d;
  logic                    upd_vld_q, upd_vld_d;
  logic signed [NWBITS-1:0] be_hold_q, be_hold_d;
  logic signed [NWBITS-1:0] dw_hold_q, dw_hold_d;

  logic signed [63:0]      on_scaled;
  logic signed [63:0]      target;
  logic                    last_beat;

  logic                    mul_vld;
  logic signed [HW-1:0]    mul_b;
  logic [SHW-1:0]          mul_shift;
  logic                    mul_neg;
  logic signed [NWBITS-1:0] mul_res;

  // One multiplier serves both phases; the FSM picks operand, shift and sign.
  mul_shift_sat #(
    .AW  (NWBITS),
    .BW  (HW),
    .OW  (NWBITS),
    .SHW (SHW)
  ) u_mul (
    .clk      (clk),
    .reset_b  (reset_b),
    .in_vld_i (mul_vld),
    .a_i      (err_q),
    .b_i      (mul_b),
    .shift_i  (mul_shift),
    .neg_i    (mul_neg),
    .res_o    (mul_res)
  );

  // Next-state, beat counting, operand muxing and the one-cycle pulses.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    on_d           = on_q;
    label_d        = label_q;
    err_d          = err_q;
    dbias_d        = dbias_q;
    be_vld_d       = 1'b0;
    upd_vld_d      = 1'b0;
    mul_vld        = 1'b0;
    mul_b          = '0;
    mul_shift      = SHW'(FRAC);
    mul_neg        = 1'b0;
    start_backprop = 1'b0;
    done           = 1'b0;

    on_scaled = sat(64'(on_q >>> OUT_SHIFT), NWBITS);
    target    = (label_q == 4'(NUM)) ? 64'(TARGET_ONE) : 64'sd0;
    last_beat = (cnt_q == COUNT_BIT2'(NHIDDEN - 1));

    case (state_q)
      S_IDLE: begin
        if (end_state2) begin
          on_d    = output_neuron;
          label_d = label;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        err_d          = NWBITS'(sat(on_scaled - target, NWBITS));
        dbias_d        = NWBITS'(sat(-(64'(err_d) >>> LR_SHIFT), NWBITS));
        start_backprop = 1'b1;
        cnt_d          = '0;
        state_d        = S_BACK;
      end
      S_BACK: begin
        mul_b     = HW'(second_layer_weight);
        mul_shift = SHW'(FRAC);
        if (weight_valid) begin
          mul_vld  = 1'b1;
          be_vld_d = 1'b1;
          cnt_d    = cnt_q + 1'b1;
          if (last_beat) begin
            state_d = S_UPDATE;
          end
        end
      end
      S_UPDATE: begin
        mul_b     = hidden_data;
        mul_shift = SHW'(FRAC + LR_SHIFT);
        mul_neg   = 1'b1;
        if (hidden_valid) begin
          mul_vld   = 1'b1;
          upd_vld_d = 1'b1;
          cnt_d     = cnt_q + 1'b1;
          if (last_beat) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Shared result register is reused, so each output keeps its own last value.
    be_hold_d = be_vld_q  ? mul_res : be_hold_q;
    dw_hold_d = upd_vld_q ? mul_res : dw_hold_q;
  end

  // State, latched sample, error terms and output hold registers.
  always_ff @(posedge clk) begin
    if (!reset_b) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      on_q      <= '0;
      label_q   <= '0;
      err_q     <= '0;
      dbias_q   <= '0;
      be_vld_q  <= 1'b0;
      upd_vld_q <= 1'b0;
      be_hold_q <= '0;
      dw_hold_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      on_q      <= on_d;
      label_q   <= label_d;
      err_q     <= err_d;
      dbias_q   <= dbias_d;
      be_vld_q  <= be_vld_d;
      upd_vld_q <= upd_vld_d;
      be_hold_q <= be_hold_d;
      dw_hold_q <= dw_hold_d;
    end
  end

  assign back_error          = be_vld_q  ? mul_res : be_hold_q;
  assign back_error_valid    = be_vld_q;
  assign delta_weight        = upd_vld_q ? mul_res : dw_hold_q;
  assign update_second_layer = upd_vld_q;
  assign delta_bias          = dbias_q;
  assign busy                = (state_q != S_IDLE);

endmodule

// File: tb/tb_second_layer_backprop.sv
// Self-checking bench for second_layer_backprop: transaction-level reference model plus literal pins.
// Latency: expects results one cycle after each beat.
// Backpressure: bench drives beats with occasional gaps.
module tb_second_layer_backprop;

  localparam int NW  = 16;
  localparam int NH  = 256;
  localparam int CB1 = 10;
  localparam int CB2 = 8;
  localparam int ONW = 2*NW + CB2 + CB1;
  localparam int HW  = NW + CB1;

  logic                  clk = 1'b0;
  logic                  reset_b = 1'b0;
  logic                  end_state2 = 1'b0;
  logic signed [ONW-1:0] output_neuron = '0;
  logic [3:0]            label = '0;
  logic                  weight_valid = 1'b0;
  logic signed [NW-1:0]  second_layer_weight = '0;
  logic                  hidden_valid = 1'b0;
  logic signed [HW-1:0]  hidden_data = '0;
  logic                  start_backprop;
  logic signed [NW-1:0]  back_error;
  logic                  back_error_valid;
  logic                  update_second_layer;
  logic signed [NW-1:0]  delta_weight;
  logic signed [NW-1:0]  delta_bias;
  logic                  busy;
  logic                  done;

  always #5 clk = ~clk;

  second_layer_backprop dut (
    .clk                 (clk),
    .reset_b             (reset_b),
    .end_state2          (end_state2),
    .output_neuron       (output_neuron),
    .label               (label),
    .weight_valid        (weight_valid),
    .second_layer_weight (second_layer_weight),
    .hidden_valid        (hidden_valid),
    .hidden_data         (hidden_data),
    .start_backprop      (start_backprop),
    .back_error          (back_error),
    .back_error_valid    (back_error_valid),
    .update_second_layer (update_second_layer),
    .delta_weight        (delta_weight),
    .delta_bias          (delta_bias),
    .busy                (busy),
    .done                (done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic signed [63:0] act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint sat16(input longint x);
    if (x > 32767) return 32767;
    if (x < -32768) return -32768;
    return x;
  endfunction

  // Reference model: phase tracker with plain integer arithmetic.
  // mode 0 idle, 1 calc, 2 weight phase, 3 hidden phase, 4 done
  int     mode = 0;
  int     left = 0;
  longint m_on = 0;
  int     m_lab = 0;
  longint m_err = 0;
  longint e_be = 0, e_dw = 0, e_db = 0;
  bit     e_bev = 0, e_upd = 0;

  always @(posedge clk) begin
    e_bev = 0;
    e_upd = 0;
    if (!reset_b) begin
      mode = 0; e_be = 0; e_dw = 0; e_db = 0;
    end else begin
      case (mode)
        0: if (end_state2) begin
             m_on = output_neuron; m_lab = int'(label); mode = 1;
           end
        1: begin
             m_err = sat16(sat16(m_on >>> 12) - ((m_lab == 0) ? 4096 : 0));
             e_db  = sat16(-(m_err >>> 7));
             mode  = 2; left = NH;
           end
        2: if (weight_valid) begin
             e_be  = sat16((m_err * longint'(second_layer_weight)) >>> 12);
             e_bev = 1; left--;
             if (left == 0) begin mode = 3; left = NH; end
           end
        3: if (hidden_valid) begin
             e_dw  = sat16(-((m_err * longint'(hidden_data)) >>> 19));
             e_upd = 1; left--;
             if (left == 0) mode = 4;
           end
        default: mode = 0;
      endcase
    end
  end

  bit     cmp_en = 0;
  int     n_start = 0, n_bev = 0, n_upd = 0, n_done = 0;
  longint last_be = 0, last_dw = 0;

  // Single compare process, sampled on the falling edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("start_backprop", start_backprop, longint'(mode == 1));
      chk("done", done, longint'(mode == 4));
      chk("busy", busy, longint'(mode != 0));
      chk("back_error_valid", back_error_valid, longint'(e_bev));
      chk("back_error", back_error, e_be);
      chk("update_second_layer", update_second_layer, longint'(e_upd));
      chk("delta_weight", delta_weight, e_dw);
      chk("delta_bias", delta_bias, e_db);
      if (start_backprop) n_start++;
      if (done) n_done++;
      if (back_error_valid) begin n_bev++; last_be = back_error; end
      if (update_second_layer) begin n_upd++; last_dw = delta_weight; end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input longint on, input int lab, input int nw,
                     input longint w0, input longint w1,
                     input longint h0, input longint h1, input int es_at);
    bit seen;
    n_start = 0; n_bev = 0; n_upd = 0; n_done = 0;
    output_neuron = ONW'(on);
    label = 4'(lab);
    end_state2 = 1'b1;
    tick();
    end_state2 = 1'b0;
    seen = 0;
    for (int k = 0; k < 8 && !seen; k++) begin
      if (start_backprop) seen = 1;
      else tick();
    end
    chk("start_seen", longint'(seen), 1);
    tick();
    hidden_data = 26'sd777;
    for (int i = 0; i < nw; i++) begin
      hidden_valid = (i < NH);
      if (i % 50 == 49) begin
        weight_valid = 1'b0;
        tick();
      end
      weight_valid = 1'b1;
      second_layer_weight = NW'((i % 2 != 0) ? w1 : w0);
      tick();
    end
    weight_valid = 1'b0;
    for (int i = 0; i < NH; i++) begin
      hidden_valid = 1'b1;
      hidden_data = HW'((i % 2 != 0) ? h1 : h0);
      end_state2 = (i == es_at);
      tick();
    end
    hidden_valid = 1'b0;
    end_state2 = 1'b0;
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      if (!busy) seen = 1;
      else tick();
    end
    chk("idle_seen", longint'(seen), 1);
    tick();
  endtask

  initial begin
    reset_b = 1'b0;
    @(posedge clk);
    cmp_en = 1;
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_start", start_backprop, 0);
    chk("rst_bev", back_error_valid, 0);
    chk("rst_upd", update_second_layer, 0);
    chk("rst_db", delta_bias, 0);
    chk("rst_be", back_error, 0);
    chk("rst_dw", delta_weight, 0);

    reset_b = 1'b1;
    weight_valid = 1'b1;
    repeat (3) tick();
    weight_valid = 1'b0;
    tick();

    // nominal: err 4096, w 2048, h 1024
    run(33554432, 0, 256, 2048, 2048, 1024, 1024, -1);
    chk("model_err_nominal", m_err, 4096);
    chk("db_nominal", delta_bias, -32);
    chk("be_nominal", last_be, 2048);
    chk("dw_nominal", last_dw, -8);
    chk("n_start_nominal", n_start, 1);
    chk("n_bev_nominal", n_bev, 256);
    chk("n_upd_nominal", n_upd, 256);
    chk("n_done_nominal", n_done, 1);

    // positive saturation, label differs from NUM
    run((64'sd1 <<< 49) - 1, 3, 256, 32767, 32767, 100, 4096, -1);
    chk("model_err_posmax", m_err, 32767);
    chk("db_posmax", delta_bias, -255);
    chk("be_posmax", last_be, 32767);
    chk("dw_posmax", last_dw, -255);

    // negative saturation
    run(-(64'sd1 <<< 49), 3, 256, 1, -4096, -32768, -33554432, -1);
    chk("model_err_negmax", m_err, -32768);
    chk("db_negmax", delta_bias, 256);
    chk("be_negmax", last_be, 32767);
    chk("dw_negmax", last_dw, -32768);

    // 300 weight beats, end_state2 during update, floor on negative product
    run(33554432, 1, 300, 100, -100, 5, -5, 100);
    chk("model_err_robust", m_err, 8192);
    chk("be_robust", last_be, -200);
    chk("dw_robust", last_dw, 1);
    chk("n_bev_robust", n_bev, 256);
    chk("n_upd_robust", n_upd, 256);
    chk("n_start_robust", n_start, 1);
    chk("n_done_robust", n_done, 1);

    // reset in the middle of the hidden phase
    output_neuron = ONW'(64'sd33554432);
    label = 4'd0;
    end_state2 = 1'b1;
    tick();
    end_state2 = 1'b0;
    tick();
    for (int i = 0; i < NH; i++) begin
      weight_valid = 1'b1;
      second_layer_weight = 16'sd2048;
      tick();
    end
    weight_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      hidden_valid = 1'b1;
      hidden_data = 26'sd1024;
      tick();
    end
    chk("pre_rst_upd", update_second_layer, 1);
    reset_b = 1'b0;
    tick();
    chk("midrst_busy", busy, 0);
    chk("midrst_upd", update_second_layer, 0);
    chk("midrst_db", delta_bias, 0);
    reset_b = 1'b1;
    hidden_valid = 1'b0;
    tick();

    // recovery after reset
    run(33554432, 0, 256, 2048, 2048, 1024, 1024, -1);
    chk("be_recover", last_be, 2048);
    chk("dw_recover", last_dw, -8);
    chk("n_done_recover", n_done, 1);

    cmp_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
